dcache_load_buffer: RTL and testbench
=====================================

// Module: dcache_load_buffer
// PURPOSE
//  Load buffer directly upstream of dcache: queues processor loads, presents them one at a time on
//  proc2Dcache_addr, and holds each address until dcache answers with a hit or a memory tag.
//  Tracks outstanding miss tags, captures data on data_tag return, and writes completed loads back
//  in order of buffer index. Sits between the LSQ/execute stage and dcache.
// PARAMETERS
//  NUM_ENTRIES  8  load buffer depth
//  IDX_BITS     3  clog2(NUM_ENTRIES)
//  DEST_BITS    5  width of destination (ROB/phys reg) tag carried with each load
// PORTS
//  clk               in   1          clock; all state updates on posedge
//  reset             in   1          asynchronous, active-high reset
//  load_valid        in   1          processor presents a load this cycle
//  load_addr         in   `XLEN      load address (8-byte line aligned, low 3 bits ignored by dcache)
//  load_dest         in   DEST_BITS  destination tag returned with the data
//  load_ready        out  1          buffer can accept a load (at least one FREE entry)
//  proc2Dcache_addr  out  `XLEN      address held to dcache
//  dc_req_valid      out  1          proc2Dcache_addr is a live request
//  dc_hit            in   1          dcache hit (registered, reflects the address of the previous cycle)
//  dc_hit_data       in   64         hit data, valid when dc_hit=1
//  dc_data_response  in   4          nonzero = memory tag assigned to the miss; 0 = keep holding
//  dc_data_tag       in   4          nonzero = memory data returned for this tag
//  dc_data           in   64         returned data, valid when dc_data_tag!=0 (dcache hit_data bus)
//  wb_valid          out  1          a completed load is presented
//  wb_dest           out  DEST_BITS  its destination tag
//  wb_data           out  64         its data
//  wb_ready          in   1          consumer accepts the writeback this cycle
// BEHAVIOUR
//  Reset (async, any cycle, including mid-miss): all entries FREE, issue FSM to I_IDLE.
//   proc2Dcache_addr=0, dc_req_valid=0, wb_valid=0, wb_dest=0, wb_data=0. load_ready=1 after release.
//   Data or tags returning after reset are dropped: no entry is in WAIT_DATA.
//  Entry state: FREE -> PENDING -> ISSUED -> (DONE | WAIT_DATA -> DONE) -> FREE.
//   Fields: addr, dest, mem_tag[3:0], data[63:0].
//  Allocate: load_valid && load_ready -> lowest-index FREE entry becomes PENDING at the next edge.
//   load_ready is computed from the current-cycle state only. An entry freed by wb this cycle
//   is not reusable until the next cycle.
//  Issue FSM (one outstanding dcache lookup):
//   I_IDLE: if any PENDING, select the lowest index, drive its addr and set dc_req_valid=1.
//           That entry becomes ISSUED. Go to I_WAIT at the next edge.
//   I_WAIT: keep proc2Dcache_addr stable and dc_req_valid=1. Each cycle, in priority order:
//     dc_data_tag!=0 -> dcache is busy returning data; hold (no state change for the ISSUED entry).
//     dc_hit=1 -> entry DONE, data=dc_hit_data; go to I_IDLE.
//     dc_data_response!=0 -> entry WAIT_DATA, mem_tag=dc_data_response; go to I_IDLE.
//     else -> hold in I_WAIT indefinitely.
//   In I_IDLE with nothing PENDING: dc_req_valid=0 and proc2Dcache_addr holds its last value.
//   The minimum turnaround is 2 cycles per load (issue cycle + response cycle).
//  Return: dc_data_tag!=0 matching a WAIT_DATA entry's mem_tag -> that entry DONE with data=dc_data.
//   No match -> ignored. Memory tags are unique among outstanding entries.
//   A return and an I_WAIT outcome cannot collide (return forces hold), so at most one entry
//   becomes DONE from dcache per cycle.
//  Writeback: wb_valid=1 iff any entry is DONE. wb_dest and wb_data come from the lowest-index DONE entry.
//   They are combinational from state. wb_valid && wb_ready -> that entry FREE at the next edge.
//   If wb_ready=0, the outputs hold stable.
//  Full: all entries non-FREE -> load_ready=0. A load_valid presented while load_ready=0 is ignored.
//  Multiple misses may be outstanding (up to NUM_ENTRIES). Hits may complete while misses wait.
//  Writeback order is by index, not by age; the consumer reorders using wb_dest.
// TESTING
//  1. Reset, load 0x100 dest 3; dc_hit=1 data 0xAA the cycle after issue -> wb_valid, wb_dest=3, wb_data=0xAA.
//  2. Miss: dc_data_response=0 for 3 cycles, then 5 -> addr held all 4 cycles.
//     Later dc_data_tag=5 with data 0xBEEF -> wb_data=0xBEEF.
//  3. Two misses (tags 2, 7), returns in order 7 then 2 -> each dest gets its own data; no cross-match.
//  4. Fill 8 entries with wb_ready=0 -> load_ready=0 and a 9th load is dropped.
//     Raise wb_ready -> load_ready=1 one cycle after the first writeback.
//  5. dc_data_tag=4 in the same cycle as dc_hit=1 for the issued entry -> issued entry holds.
//     Tag-4 entry completes; issued entry completes on the next hit.
//  6. Assert reset while 3 misses are outstanding -> all outputs zero, load_ready=1.
//     A later dc_data_tag return produces no wb_valid.

Source files
------------

// File: rtl/dcache_load_buffer.sv
// dcache_load_buffer
//   Load buffer that sits directly upstream of the data cache. It queues
//   processor loads, presents them to dcache one at a time, and keeps each
//   address stable until dcache answers with either a hit or a memory tag.
//   Misses park in WAIT_DATA until their tag returns. Completed loads are
//   written back lowest buffer index first.
//
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     load_valid/addr/dest  incoming load; load_ready when an entry is FREE
//     proc2Dcache_addr      address held to dcache; dc_req_valid marks it live
//     dc_hit/dc_hit_data    registered hit for the previous cycle's address
//     dc_data_response      nonzero memory tag assigned to a miss
//     dc_data_tag/dc_data   memory data returning for a tag
//     wb_valid/dest/data    completed load, handed off when wb_ready is high
module dcache_load_buffer #(
  parameter int XLEN        = 64,
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_BITS    = 3,
  parameter int DEST_BITS   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [XLEN-1:0]      load_addr,
  input  logic [DEST_BITS-1:0] load_dest,
  output logic                 load_ready,
  output logic [XLEN-1:0]      proc2Dcache_addr,
  output logic                 dc_req_valid,
  input  logic                 dc_hit,
  input  logic [63:0]          dc_hit_data,
  input  logic [3:0]           dc_data_response,
  input  logic [3:0]           dc_data_tag,
  input  logic [63:0]          dc_data,
  output logic                 wb_valid,
  output logic [DEST_BITS-1:0] wb_dest,
  output logic [63:0]          wb_data,
  input  logic                 wb_ready
);

  localparam logic [2:0] E_FREE      = 3'd0;
  localparam logic [2:0] E_PENDING   = 3'd1;
  localparam logic [2:0] E_ISSUED    = 3'd2;
  localparam logic [2:0] E_WAIT_DATA = 3'd3;
  localparam logic [2:0] E_DONE      = 3'd4;

  localparam logic [0:0] I_IDLE = 1'b0;
  localparam logic [0:0] I_WAIT = 1'b1;

  logic [2:0]           ent_state   [NUM_ENTRIES];
  logic [XLEN-1:0]      ent_addr    [NUM_ENTRIES];
  logic [DEST_BITS-1:0] ent_dest    [NUM_ENTRIES];
  logic [3:0]           ent_mem_tag [NUM_ENTRIES];
  logic [63:0]          ent_data    [NUM_ENTRIES];

  logic [0:0]           issue_state;
  logic [IDX_BITS-1:0]  issued_idx;
  logic [XLEN-1:0]      held_addr;

  logic                 any_free;
  logic                 any_pending;
  logic                 any_done;
  logic [IDX_BITS-1:0]  free_idx;
  logic [IDX_BITS-1:0]  pend_idx;
  logic [IDX_BITS-1:0]  done_idx;
  logic                 issue_now;

  // Lowest-index priority encoders over the entry states. Scanning from the
  // top down lets the last hit win, which is the lowest matching index.
  always_comb begin
    any_free    = 1'b0;
    any_pending = 1'b0;
    any_done    = 1'b0;
    free_idx    = '0;
    pend_idx    = '0;
    done_idx    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_state[i] == E_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_BITS'(i);
      end
      if (ent_state[i] == E_PENDING) begin
        any_pending = 1'b1;
        pend_idx    = IDX_BITS'(i);
      end
      if (ent_state[i] == E_DONE) begin
        any_done = 1'b1;
        done_idx = IDX_BITS'(i);
      end
    end
  end

  // The issue cycle drives the pending address straight through. Every other
  // cycle shows the registered copy, which keeps the address stable in I_WAIT
  // and holds the last value once the buffer goes idle.
  assign issue_now        = (issue_state == I_IDLE) && any_pending;
  assign dc_req_valid     = issue_now || (issue_state == I_WAIT);
  assign proc2Dcache_addr = issue_now ? ent_addr[pend_idx] : held_addr;
  assign load_ready       = any_free;
  assign wb_valid         = any_done;
  assign wb_dest          = any_done ? ent_dest[done_idx] : '0;
  assign wb_data          = any_done ? ent_data[done_idx] : 64'd0;

  // Entry and issue-FSM state. Allocation, issue, the I_WAIT outcome, a tag
  // return and a writeback always touch different entries. Allocation picks
  // a FREE entry, issue picks a PENDING one, the I_WAIT outcome acts on the
  // ISSUED one, a return acts on a WAIT_DATA one and writeback frees a DONE
  // one. Because of that, these updates can sit side by side without ordering
  // concerns. A return while in I_WAIT forces the issued entry to hold, so
  // only one entry can complete from dcache per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_state[i]   <= E_FREE;
        ent_addr[i]    <= '0;
        ent_dest[i]    <= '0;
        ent_mem_tag[i] <= '0;
        ent_data[i]    <= '0;
      end
      issue_state <= I_IDLE;
      issued_idx  <= '0;
      held_addr   <= '0;
    end else begin
      if (load_valid && any_free) begin
        ent_state[free_idx] <= E_PENDING;
        ent_addr[free_idx]  <= load_addr;
        ent_dest[free_idx]  <= load_dest;
      end

      if (issue_now) begin
        ent_state[pend_idx] <= E_ISSUED;
        issued_idx          <= pend_idx;
        held_addr           <= ent_addr[pend_idx];
        issue_state         <= I_WAIT;
      end else if (issue_state == I_WAIT && dc_data_tag == 4'd0) begin
        if (dc_hit) begin
          ent_state[issued_idx] <= E_DONE;
          ent_data[issued_idx]  <= dc_hit_data;
          issue_state           <= I_IDLE;
        end else if (dc_data_response != 4'd0) begin
          ent_state[issued_idx]   <= E_WAIT_DATA;
          ent_mem_tag[issued_idx] <= dc_data_response;
          issue_state             <= I_IDLE;
        end
      end

      if (dc_data_tag != 4'd0) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (ent_state[i] == E_WAIT_DATA && ent_mem_tag[i] == dc_data_tag) begin
            ent_state[i] <= E_DONE;
            ent_data[i]  <= dc_data;
          end
        end
      end

      if (any_done && wb_ready) begin
        ent_state[done_idx] <= E_FREE;
      end
    end
  end

endmodule

// File: tb/tb_dcache_load_buffer.sv
module tb_dcache_load_buffer;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [63:0] load_addr;
  logic [4:0]  load_dest;
  logic        load_ready;
  logic [63:0] proc2Dcache_addr;
  logic        dc_req_valid;
  logic        dc_hit;
  logic [63:0] dc_hit_data;
  logic [3:0]  dc_data_response;
  logic [3:0]  dc_data_tag;
  logic [63:0] dc_data;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [63:0] wb_data;
  logic        wb_ready;

  int checkCount;
  int errorCount;

  dcache_load_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .load_valid       (load_valid),
    .load_addr        (load_addr),
    .load_dest        (load_dest),
    .load_ready       (load_ready),
    .proc2Dcache_addr (proc2Dcache_addr),
    .dc_req_valid     (dc_req_valid),
    .dc_hit           (dc_hit),
    .dc_hit_data      (dc_hit_data),
    .dc_data_response (dc_data_response),
    .dc_data_tag      (dc_data_tag),
    .dc_data          (dc_data),
    .wb_valid         (wb_valid),
    .wb_dest          (wb_dest),
    .wb_data          (wb_data),
    .wb_ready         (wb_ready)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log a miss.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive every input for the current cycle, then let combinational outputs settle.
  task automatic applyStimulus(input logic lv, input logic [63:0] addr, input logic [4:0] dest,
                               input logic hit, input logic [63:0] hitData,
                               input logic [3:0] resp, input logic [3:0] tag,
                               input logic [63:0] data, input logic wbr);
    load_valid       = lv;
    load_addr        = addr;
    load_dest        = dest;
    dc_hit           = hit;
    dc_hit_data      = hitData;
    dc_data_response = resp;
    dc_data_tag      = tag;
    dc_data          = data;
    wb_ready         = wbr;
    #1;
  endtask

  // Step past the next rising edge so inputs change away from it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Quiet cycle with only wb_ready chosen.
  task automatic idle(input logic wbr);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, wbr);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_addr", proc2Dcache_addr, 64'h0);
    checkOutput("rst_req", {63'd0, dc_req_valid}, 64'd0);
    checkOutput("rst_wbv", {63'd0, wb_valid}, 64'd0);
    checkOutput("rst_wbd", {59'd0, wb_dest}, 64'd0);
    checkOutput("rst_wbdata", wb_data, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready", {63'd0, load_ready}, 64'd1);
    nextCycle();

    // 1: single hit
    applyStimulus(1, 64'h100, 5'd3, 0, 0, 0, 0, 0, 1);
    nextCycle();
    idle(1);
    checkOutput("t1_issue_req", {63'd0, dc_req_valid}, 64'd1);
    checkOutput("t1_issue_addr", proc2Dcache_addr, 64'h100);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 64'hAA, 0, 0, 0, 1);
    checkOutput("t1_wait_addr", proc2Dcache_addr, 64'h100);
    nextCycle();
    idle(0);
    checkOutput("t1_wbv", {63'd0, wb_valid}, 64'd1);
    checkOutput("t1_wbdest", {59'd0, wb_dest}, 64'd3);
    checkOutput("t1_wbdata", wb_data, 64'hAA);
    checkOutput("t1_idle_req", {63'd0, dc_req_valid}, 64'd0);
    checkOutput("t1_idle_addr", proc2Dcache_addr, 64'h100);
    nextCycle();
    idle(1);
    checkOutput("t1_hold_dest", {59'd0, wb_dest}, 64'd3);
    nextCycle();
    idle(1);
    checkOutput("t1_freed", {63'd0, wb_valid}, 64'd0);

    // 2: miss with delayed response
    applyStimulus(1, 64'h200, 5'd4, 0, 0, 0, 0, 0, 1);
    nextCycle();
    idle(1);
    checkOutput("t2_issue_addr", proc2Dcache_addr, 64'h200);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("t2_hold_addr", proc2Dcache_addr, 64'h200);
      checkOutput("t2_hold_req", {63'd0, dc_req_valid}, 64'd1);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 4'd5, 0, 0, 1);
    checkOutput("t2_resp_addr", proc2Dcache_addr, 64'h200);
    nextCycle();
    idle(1);
    checkOutput("t2_miss_req", {63'd0, dc_req_valid}, 64'd0);
    checkOutput("t2_miss_wbv", {63'd0, wb_valid}, 64'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd5, 64'hBEEF, 1);
    nextCycle();
    idle(1);
    checkOutput("t2_wbdest", {59'd0, wb_dest}, 64'd4);
    checkOutput("t2_wbdata", wb_data, 64'hBEEF);
    nextCycle();

    // 3: two misses returning out of order
    applyStimulus(1, 64'h300, 5'd10, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 64'h308, 5'd11, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_issue0", proc2Dcache_addr, 64'h300);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 4'd2, 0, 0, 0);
    nextCycle();
    idle(0);
    checkOutput("t3_issue1", proc2Dcache_addr, 64'h308);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 4'd7, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd7, 64'h7777, 0);
    checkOutput("t3_none_yet", {63'd0, wb_valid}, 64'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd2, 64'h2222, 0);
    checkOutput("t3_first_dest", {59'd0, wb_dest}, 64'd11);
    checkOutput("t3_first_data", wb_data, 64'h7777);
    nextCycle();
    idle(1);
    checkOutput("t3_low_dest", {59'd0, wb_dest}, 64'd10);
    checkOutput("t3_low_data", wb_data, 64'h2222);
    nextCycle();
    idle(1);
    checkOutput("t3_next_dest", {59'd0, wb_dest}, 64'd11);
    checkOutput("t3_next_data", wb_data, 64'h7777);
    nextCycle();
    idle(1);
    checkOutput("t3_drained", {63'd0, wb_valid}, 64'd0);
    nextCycle();

    // 4: fill all entries with writeback stalled
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 64'h400 + 64'(8 * i), 5'(16 + i), 0, 0, 0, 0, 0, 0);
      checkOutput("t4_ready_fill", {63'd0, load_ready}, 64'd1);
      nextCycle();
    end
    applyStimulus(1, 64'h999, 5'd31, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_full", {63'd0, load_ready}, 64'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 64'hD0, 0, 0, 0, 0);
    checkOutput("t4_wait_addr", proc2Dcache_addr, 64'h400);
    nextCycle();
    idle(0);
    checkOutput("t4_wbdest", {59'd0, wb_dest}, 64'd16);
    checkOutput("t4_wbdata", wb_data, 64'hD0);
    checkOutput("t4_still_full", {63'd0, load_ready}, 64'd0);
    checkOutput("t4_issue_next", proc2Dcache_addr, 64'h408);
    nextCycle();
    idle(1);
    checkOutput("t4_full_on_wb", {63'd0, load_ready}, 64'd0);
    nextCycle();
    idle(0);
    checkOutput("t4_ready_after", {63'd0, load_ready}, 64'd1);
    checkOutput("t4_no_wb", {63'd0, wb_valid}, 64'd0);
    pulseReset();
    nextCycle();

    // 5: tag return collides with a hit for the issued entry
    applyStimulus(1, 64'h600, 5'd5, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 64'h608, 5'd6, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 4'd4, 0, 0, 0);
    nextCycle();
    idle(0);
    checkOutput("t5_issue1", proc2Dcache_addr, 64'h608);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 64'hBAD, 0, 4'd4, 64'h4444, 0);
    nextCycle();
    idle(0);
    checkOutput("t5_tag_dest", {59'd0, wb_dest}, 64'd5);
    checkOutput("t5_tag_data", wb_data, 64'h4444);
    checkOutput("t5_still_req", {63'd0, dc_req_valid}, 64'd1);
    checkOutput("t5_still_addr", proc2Dcache_addr, 64'h608);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 64'h6666, 0, 0, 0, 1);
    nextCycle();
    idle(1);
    checkOutput("t5_hit_dest", {59'd0, wb_dest}, 64'd6);
    checkOutput("t5_hit_data", wb_data, 64'h6666);
    nextCycle();
    idle(1);
    checkOutput("t5_drained", {63'd0, wb_valid}, 64'd0);
    nextCycle();

    // 6: reset with three misses outstanding
    applyStimulus(1, 64'h700, 5'd20, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 64'h708, 5'd21, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 64'h710, 5'd22, 0, 0, 4'd1, 0, 0, 0);
    nextCycle();
    idle(0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 4'd2, 0, 0, 0);
    nextCycle();
    idle(0);
    checkOutput("t6_issue2", proc2Dcache_addr, 64'h710);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 4'd3, 0, 0, 0);
    nextCycle();
    idle(0);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_addr", proc2Dcache_addr, 64'h0);
    checkOutput("t6_rst_req", {63'd0, dc_req_valid}, 64'd0);
    checkOutput("t6_rst_wbv", {63'd0, wb_valid}, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("t6_ready", {63'd0, load_ready}, 64'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd2, 64'hFFFF, 0);
    nextCycle();
    idle(0);
    checkOutput("t6_no_wb", {63'd0, wb_valid}, 64'd0);
    checkOutput("t6_no_req", {63'd0, dc_req_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
